// File: rtl/dbgu_pkg.sv
// Shared definitions for the debug-UART command engine: opcodes, FSM states,
// argument byte counts and byte-lane helpers.
package dbgu_pkg;

    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h04;
    localparam logic [7:0] OP_READ     = 8'h05;
    localparam logic [7:0] OP_CPU_CLK  = 8'h22;

    localparam logic [2:0] NARGS_SET_ADDR = 3'd4;
    localparam logic [2:0] NARGS_WRITE    = 3'd4;
    localparam logic [2:0] NARGS_CPU_CLK  = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARGS    = 3'd1,
        S_MEM_WR  = 3'd2,
        S_MEM_RD  = 3'd3,
        S_TX_RESP = 3'd4
    } state_t;

    function automatic logic [2:0] arg_count(input logic [7:0] op);
        case (op)
            OP_SET_ADDR: arg_count = NARGS_SET_ADDR;
            OP_WRITE:    arg_count = NARGS_WRITE;
            OP_CPU_CLK:  arg_count = NARGS_CPU_CLK;
            default:     arg_count = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = w[7:0];
            2'd1:    byte_of = w[15:8];
            2'd2:    byte_of = w[23:16];
            default: byte_of = w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/dbgu_timeout_cnt.sv
// Reloadable down-counter; o_expired is high once TIMEOUT_CYCLES enabled
// cycles have elapsed since the last load.
module dbgu_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= LOAD_VAL;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/dbgu_cmd_engine.sv
// Debug-UART command responder: decodes opcode/argument bytes, performs word
// accesses on a picorv32-native port and streams read data back LSB first.
module dbgu_cmd_engine
    import dbgu_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 65535,
    parameter logic [31:0] ADDR_RESET     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        cpu_clk_en,
    output logic        busy,
    output logic        rx_overrun,
    output logic [2:0]  dbg_state
);
    // Handshakes: a memory access completes on the edge where mem_valid && mem_ready;
    // a response byte is consumed on the edge where tx_valid && tx_ready.
    state_t      r_state, w_state_next;
    logic [7:0]  r_opcode;
    logic [2:0]  r_cnt;
    logic [31:0] r_arg, r_addr, r_rdata, r_mem_wdata;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid, r_mem_valid, r_cpu_clk_en, r_rx_overrun;
    logic [3:0]  r_mem_wstrb;

    logic [31:0] w_arg_next;
    logic        w_last_arg, w_mem_done, w_tx_done, w_tmr_expired, w_tmr_load, w_tmr_en;
    logic        w_in_access;

    assign w_last_arg  = (r_cnt == arg_count(r_opcode) - 3'd1);
    assign w_mem_done  = r_mem_valid && mem_ready;
    assign w_tx_done   = r_tx_valid && tx_ready;
    assign w_in_access = (r_state == S_MEM_WR) || (r_state == S_MEM_RD) || (r_state == S_TX_RESP);
    assign w_tmr_load  = rx_valid && ((r_state == S_IDLE) || (r_state == S_ARGS));
    assign w_tmr_en    = (r_state == S_ARGS);

    dbgu_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_tmr_load),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    // Argument register with the incoming byte merged in, so the final byte's
    // action can be applied on the same edge that samples it.
    always_comb begin
        w_arg_next = r_arg;
        case (r_cnt[1:0])
            2'd0:    w_arg_next[7:0]   = rx_data;
            2'd1:    w_arg_next[15:8]  = rx_data;
            2'd2:    w_arg_next[23:16] = rx_data;
            default: w_arg_next[31:24] = rx_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_READ)                  w_state_next = S_MEM_RD;
                    else if (arg_count(rx_data) != 3'd0)     w_state_next = S_ARGS;
                end
            end
            S_ARGS: begin
                if (rx_valid) begin
                    if (w_last_arg) w_state_next = (r_opcode == OP_WRITE) ? S_MEM_WR : S_IDLE;
                end else if (w_tmr_expired) begin
                    w_state_next = S_IDLE;
                end
            end
            S_MEM_WR:  if (w_mem_done) w_state_next = S_IDLE;
            S_MEM_RD:  if (w_mem_done) w_state_next = S_TX_RESP;
            S_TX_RESP: if (w_tx_done && (r_cnt == 3'd3)) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode     <= 8'h00;
            r_cnt        <= 3'd0;
            r_arg        <= 32'h0;
            r_addr       <= ADDR_RESET;
            r_rdata      <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_wstrb  <= 4'h0;
            r_mem_valid  <= 1'b0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_cpu_clk_en <= 1'b1;
            r_rx_overrun <= 1'b0;
        end else begin
            if (rx_valid && w_in_access) r_rx_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_opcode <= rx_data;
                        r_cnt    <= 3'd0;
                        r_arg    <= 32'h0;
                        if (rx_data == OP_READ) r_mem_valid <= 1'b1;
                    end
                end
                S_ARGS: begin
                    if (rx_valid) begin
                        r_arg <= w_arg_next;
                        r_cnt <= r_cnt + 3'd1;
                        if (w_last_arg) begin
                            case (r_opcode)
                                OP_SET_ADDR: r_addr       <= w_arg_next;
                                OP_CPU_CLK:  r_cpu_clk_en <= w_arg_next[0];
                                OP_WRITE: begin
                                    r_mem_wdata <= w_arg_next;
                                    r_mem_wstrb <= 4'hF;
                                    r_mem_valid <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end else if (w_tmr_expired) begin
                        r_arg <= 32'h0;
                    end
                end
                S_MEM_WR, S_MEM_RD: begin
                    if (w_mem_done) begin
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= 4'h0;
                        r_addr      <= r_addr + 32'd4;
                        r_rdata     <= mem_rdata;
                        r_cnt       <= 3'd0;
                    end
                end
                S_TX_RESP: begin
                    // tx_valid is only low here on the entry cycle.
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= byte_of(r_rdata, 2'd0);
                    end else if (tx_ready) begin
                        if (r_cnt == 3'd3) begin
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_tx_data <= byte_of(r_rdata, r_cnt[1:0] + 2'd1);
                            r_cnt     <= r_cnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign mem_valid  = r_mem_valid;
    assign mem_addr   = {r_addr[31:2], 2'b00};
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;
    assign cpu_clk_en = r_cpu_clk_en;
    assign busy       = (r_state != S_IDLE);
    assign rx_overrun = r_rx_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_dbgu_cmd_engine.sv
// Scoreboard bench for dbgu_cmd_engine: a command-level model predicts memory
// transactions and response bytes; independent monitors check the DUT outputs.
module tb_dbgu_cmd_engine;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        cpu_clk_en;
    logic        busy;
    logic        rx_overrun;
    logic [2:0]  dbg_state;

    dbgu_cmd_engine #(.TIMEOUT_CYCLES(TMO), .ADDR_RESET(32'h0)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .cpu_clk_en(cpu_clk_en), .busy(busy), .rx_overrun(rx_overrun),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // {is_write, addr, wdata}
    logic [64:0] exp_mem_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] sim_mem[logic [31:0]];
    logic [31:0] m_addr;
    logic        m_clk_en;
    int          mem_stall = 0;
    int          tx_stall = 0;
    bit          tx_hold = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
        end
    endtask

    task automatic cmd(input logic [7:0] op, input logic [31:0] arg);
        logic [31:0] a, w;
        wait_idle();
        case (op)
            8'h01: begin
                m_addr = arg;
                send_byte(op);
                for (int i = 0; i < 4; i++) send_byte(8'(arg >> (8 * i)));
            end
            8'h04: begin
                a = m_addr & 32'hFFFF_FFFC;
                exp_mem_q.push_back({1'b1, a, arg});
                ref_mem[a] = arg;
                m_addr = m_addr + 32'd4;
                send_byte(op);
                for (int i = 0; i < 4; i++) send_byte(8'(arg >> (8 * i)));
            end
            8'h05: begin
                a = m_addr & 32'hFFFF_FFFC;
                w = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
                exp_mem_q.push_back({1'b0, a, 32'h0});
                for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'(w >> (8 * i)));
                m_addr = m_addr + 32'd4;
                send_byte(op);
            end
            8'h22: begin
                send_byte(op);
                check("clk_en_before", {31'h0, cpu_clk_en}, {31'h0, m_clk_en});
                send_byte(arg[7:0]);
                m_clk_en = arg[0];
                check("clk_en_after", {31'h0, cpu_clk_en}, {31'h0, m_clk_en});
            end
            default: send_byte(op);
        endcase
    endtask

    // Memory responder: mem_ready after mem_stall wait cycles, data from sim_mem.
    initial begin
        int mcnt;
        mcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_valid) begin
                if (mcnt >= mem_stall) begin
                    mem_ready = 1'b1;
                    mcnt = 0;
                    mem_rdata = sim_mem.exists(mem_addr) ? sim_mem[mem_addr] : init_word(mem_addr);
                end else begin
                    mcnt++;
                end
            end
        end
    end

    // Transmitter: tx_ready after tx_stall wait cycles, never while tx_hold.
    initial begin
        int tcnt;
        tcnt = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = 1'b0;
            if (tx_valid && !tx_hold) begin
                if (tcnt >= tx_stall) begin
                    tx_ready = 1'b1;
                    tcnt = 0;
                end else begin
                    tcnt++;
                end
            end
        end
    end

    // Memory monitor.
    initial begin
        logic [64:0] item;
        logic [67:0] snap;
        bit pend;
        pend = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_valid) begin
                if (pend) begin
                    check("mem_addr_stable",  mem_addr,  snap[67:36]);
                    check("mem_wdata_stable", mem_wdata, snap[35:4]);
                    check("mem_wstrb_stable", {28'h0, mem_wstrb}, {28'h0, snap[3:0]});
                end
                if (mem_ready) begin
                    pend = 0;
                    if (exp_mem_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL mem_unexpected: addr %h wstrb %h with no access expected", mem_addr, mem_wstrb);
                    end else begin
                        item = exp_mem_q.pop_front();
                        check("mem_addr", mem_addr, item[63:32]);
                        check("mem_wstrb", {28'h0, mem_wstrb}, item[64] ? 32'hF : 32'h0);
                        if (item[64]) check("mem_wdata", mem_wdata, item[31:0]);
                    end
                    if (mem_wstrb == 4'hF) sim_mem[mem_addr] = mem_wdata;
                end else begin
                    pend = 1;
                    snap = {mem_addr, mem_wdata, mem_wstrb};
                end
            end else begin
                pend = 0;
            end
        end
    end

    // Transmit monitor.
    initial begin
        logic [7:0] snap;
        bit pend;
        pend = 0;
        snap = 8'h0;
        forever begin
            @(negedge clk);
            if (!reset && tx_valid) begin
                if (pend) check("tx_data_stable", {24'h0, tx_data}, {24'h0, snap});
                if (tx_ready) begin
                    pend = 0;
                    if (exp_tx_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_unexpected: byte %h with no byte expected", tx_data);
                    end else begin
                        check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
                    end
                end else begin
                    pend = 1;
                    snap = tx_data;
                end
            end else begin
                pend = 0;
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a;
        int kind;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        m_addr   = 32'h0;
        m_clk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_valid",   {31'h0, tx_valid},   32'h0);
        check("rst_tx_data",    {24'h0, tx_data},    32'h0);
        check("rst_mem_valid",  {31'h0, mem_valid},  32'h0);
        check("rst_mem_wstrb",  {28'h0, mem_wstrb},  32'h0);
        check("rst_mem_wdata",  mem_wdata,           32'h0);
        check("rst_mem_addr",   mem_addr,            32'h0);
        check("rst_cpu_clk_en", {31'h0, cpu_clk_en}, 32'h1);
        check("rst_busy",       {31'h0, busy},       32'h0);
        check("rst_rx_overrun", {31'h0, rx_overrun}, 32'h0);
        reset = 1'b0;

        cmd(8'h22, 32'h00);
        cmd(8'h22, 32'h01);

        mem_stall = 3;
        cmd(8'h01, 32'h0002_0000);
        cmd(8'h04, 32'hAABB_CCDD);
        cmd(8'h04, 32'hAA80_AA80);
        mem_stall = 0;

        wait_idle();
        tx_stall = 5;
        cmd(8'h01, 32'h0002_0000);
        cmd(8'h05, 32'h0);
        cmd(8'h05, 32'h0);
        wait_idle();
        tx_stall = 0;

        cmd(8'h01, 32'hFFFF_FFFC);
        cmd(8'h05, 32'h0);
        cmd(8'h05, 32'h0);

        // Partial WRITE abandoned by the inter-byte timeout.
        wait_idle();
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        check("busy_in_args", {31'h0, busy}, 32'h1);
        repeat (TMO + 14) @(negedge clk);
        check("busy_after_timeout", {31'h0, busy}, 32'h0);
        cmd(8'h05, 32'h0);

        cmd(8'h7E, 32'h0);
        cmd(8'h05, 32'h0);

        for (int i = 0; i < 40; i++) begin
            wait_idle();
            mem_stall = $urandom_range(0, 3);
            tx_stall  = $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                else a = 32'h0002_0000 + 32'($urandom_range(0, 31));
                cmd(8'h01, a);
            end else if (kind < 5) begin
                cmd(8'h04, $urandom);
            end else if (kind < 8) begin
                cmd(8'h05, 32'h0);
            end else if (kind == 8) begin
                cmd(8'h22, 32'($urandom_range(0, 255)));
            end else begin
                cmd(8'($urandom_range(8'h30, 8'hFF)), 32'h0);
            end
        end
        wait_idle();
        check("no_overrun_yet", {31'h0, rx_overrun}, 32'h0);

        // Byte arriving during a stalled response is dropped and flagged.
        mem_stall = 0;
        tx_stall  = 0;
        tx_hold   = 1;
        cmd(8'h05, 32'h0);
        n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tx_valid_seen", {31'h0, tx_valid}, 32'h1);
        send_byte(8'h01);
        check("rx_overrun_set", {31'h0, rx_overrun}, 32'h1);
        tx_hold = 0;
        wait_idle();
        check("idle_after_drain", {31'h0, busy}, 32'h0);
        cmd(8'h05, 32'h0);
        wait_idle();
        check("rx_overrun_sticky", {31'h0, rx_overrun}, 32'h1);

        repeat (5) @(negedge clk);
        check("mem_q_empty", exp_mem_q.size(), 32'h0);
        check("tx_q_empty",  exp_tx_q.size(),  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
